// File: rtl/lap_ctrl.sv
// Lap-time capture ring buffer for a BCD stopwatch: capture, recall/step and clear of laps.
// Optional define LAP_CTRL_WRAP_EN: a lap taken while full overwrites the oldest entry.
module lap_ctrl #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [15:0]              live_d,
   input  logic                     lap_p,
   input  logic                     recall_p,
   input  logic                     next_p,
   input  logic                     clear_p,
   output logic [15:0]              disp_d,
   output logic                     recall,
   output logic [$clog2(DEPTH)-1:0] idx,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     busy,
   output logic                     beep,
   output logic                     err
);

   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [1:0] LIVE    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] RECALL  = 2'd2;
   localparam logic [1:0] CLEAR   = 2'd3;

   localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE_CNT   = (AW+1)'(1);
   localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);

`ifdef LAP_CTRL_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   logic [1:0]    state, state_nx;
   logic [AW-1:0] wp, wp_nx;
   logic [AW-1:0] idx_nx;
   logic [AW:0]   count_nx;
   logic [AW-1:0] clr_cnt, clr_cnt_nx;
   logic [15:0]   cap_val, cap_val_nx;
   logic [15:0]   disp_nx;
   logic          beep_nx, err_nx;
   logic          armed;

   logic [15:0]   mem [DEPTH];
   logic          mem_we;
   logic [AW-1:0] mem_wa;
   logic [15:0]   mem_wd;

   logic [AW-1:0] newest, oldest;
   logic          is_full, go_clear;

   assign newest   = wp - AW'(1);
   assign oldest   = wp - count[AW-1:0];
   assign is_full  = (count == FULL_CNT);
   // armed is low for the first edge after reset release so no pulse is taken there
   assign go_clear = armed && clear_p && (state != CLEAR);

   assign recall = (state == RECALL);
   assign busy   = (state == CLEAR);
   assign full   = is_full;

   always_comb begin
      state_nx   = state;
      wp_nx      = wp;
      idx_nx     = idx;
      count_nx   = count;
      clr_cnt_nx = clr_cnt;
      cap_val_nx = cap_val;
      disp_nx    = disp_d;
      beep_nx    = 1'b0;
      err_nx     = 1'b0;
      mem_we     = 1'b0;
      mem_wa     = wp;
      mem_wd     = cap_val;

      if (go_clear) begin
         state_nx   = CLEAR;
         clr_cnt_nx = '0;
         idx_nx     = '0;
         disp_nx    = '0;
      end else begin
         case (state)
            LIVE: begin
               disp_nx = live_d;
               if (armed && lap_p) begin
                  if (is_full && !WRAP_EN) begin
                     err_nx = 1'b1;
                  end else begin
                     cap_val_nx = live_d;
                     state_nx   = CAPTURE;
                  end
               end else if (armed && recall_p) begin
                  if (count != '0) begin
                     state_nx = RECALL;
                     idx_nx   = newest;
                     beep_nx  = 1'b1;
                  end else begin
                     err_nx = 1'b1;
                  end
               end
            end

            CAPTURE: begin
               disp_nx  = live_d;
               mem_we   = 1'b1;
               wp_nx    = wp + AW'(1);
               count_nx = is_full ? count : count + ONE_CNT;
               beep_nx  = 1'b1;
               state_nx = LIVE;
            end

            RECALL: begin
               disp_nx = mem[idx];
               if (lap_p) begin
                  err_nx = 1'b1;
               end else if (recall_p) begin
                  state_nx = LIVE;
                  idx_nx   = '0;
                  beep_nx  = 1'b1;
               end else if (next_p && (count > ONE_CNT)) begin
                  idx_nx  = (idx == oldest) ? newest : idx - AW'(1);
                  beep_nx = 1'b1;
               end
            end

            CLEAR: begin
               disp_nx = '0;
               mem_we  = 1'b1;
               mem_wa  = clr_cnt;
               mem_wd  = '0;
               if (clr_cnt == LAST_SLOT) begin
                  state_nx = LIVE;
                  count_nx = '0;
                  wp_nx    = '0;
                  idx_nx   = '0;
                  beep_nx  = 1'b1;
               end else begin
                  clr_cnt_nx = clr_cnt + AW'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= LIVE;
         wp      <= '0;
         idx     <= '0;
         count   <= '0;
         clr_cnt <= '0;
         cap_val <= '0;
         disp_d  <= '0;
         beep    <= 1'b0;
         err     <= 1'b0;
         armed   <= 1'b0;
      end else begin
         state   <= state_nx;
         wp      <= wp_nx;
         idx     <= idx_nx;
         count   <= count_nx;
         clr_cnt <= clr_cnt_nx;
         cap_val <= cap_val_nx;
         disp_d  <= disp_nx;
         beep    <= beep_nx;
         err     <= err_nx;
         armed   <= 1'b1;
      end
   end

   // Lap storage is deliberately left out of reset; count gates what is readable.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

endmodule

// File: tb/tb_lap_ctrl.sv
// Self-checking bench for lap_ctrl: scoreboard of expected display values plus a lap model.
module tb_lap_ctrl;

   localparam int DEPTH = 8;
`ifdef LAP_CTRL_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] live_d = 16'h0000;
   logic        lap_p = 1'b0, recall_p = 1'b0, next_p = 1'b0, clear_p = 1'b0;
   logic [15:0] disp_d;
   logic        recall, full, busy, beep, err;
   logic [2:0]  idx;
   logic [3:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] exp_q[$];
   logic [15:0] m_mem[DEPTH];
   int          m_wp = 0, m_cnt = 0, m_idx = 0;

   lap_ctrl #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .live_d(live_d), .lap_p(lap_p), .recall_p(recall_p),
      .next_p(next_p), .clear_p(clear_p), .disp_d(disp_d), .recall(recall), .idx(idx),
      .count(count), .full(full), .busy(busy), .beep(beep), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_lap(input logic [15:0] v);
      if (m_cnt < DEPTH || WRAP) begin
         m_mem[m_wp] = v;
         m_wp = (m_wp + 1) % DEPTH;
         if (m_cnt < DEPTH) m_cnt++;
      end
   endfunction

   function automatic void model_next();
      int old_i, new_i;
      old_i = (m_wp - m_cnt + DEPTH) % DEPTH;
      new_i = (m_wp + DEPTH - 1) % DEPTH;
      if (m_cnt > 1) m_idx = (m_idx == old_i) ? new_i : (m_idx + DEPTH - 1) % DEPTH;
   endfunction

   // Drives one lap; returns display after the lap edge, err on it, and beep after capture.
   task automatic do_lap(input logic [15:0] v, output logic [15:0] d_cap,
                         output logic e_cap, output logic b_cap);
      live_d = v;
      lap_p  = 1'b1;
      tick();
      d_cap = disp_d;
      e_cap = err;
      lap_p = 1'b0;
      tick();
      b_cap = beep;
      model_lap(v);
   endtask

   // Steps idx in recall and scores the display one cycle later.
   task automatic step_next(input string tag);
      logic [15:0] e;
      next_p = 1'b1;
      tick();
      next_p = 1'b0;
      model_next();
      exp_q.push_back(m_mem[m_idx]);
      n_tests++;
      if (idx !== 3'(m_idx)) begin
         n_fail++; $display("FAIL %s_idx: got %0d want %0d", tag, idx, m_idx);
      end
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (disp_d !== e) begin
         n_fail++; $display("FAIL %s_disp: got %h want %h", tag, disp_d, e);
      end
   endtask

   task automatic test_reset();
      live_d = 16'h1234;
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({disp_d, count, idx} !== '0) begin
         n_fail++; $display("FAIL reset_regs: got disp=%h cnt=%0d idx=%0d want 0", disp_d, count, idx);
      end
      n_tests++;
      if ({recall, full, busy, beep, err} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 00000", {recall, full, busy, beep, err});
      end
      tick();
      tick();
      rst_n    = 1'b1;
      recall_p = 1'b1;   // lands on the first edge after release and must be ignored
      tick();
      recall_p = 1'b0;
      exp_q.push_back(16'h1234);
      n_tests++;
      if (disp_d !== exp_q[0]) begin
         n_fail++; $display("FAIL live_latency: got %h want %h", disp_d, exp_q[0]);
      end
      void'(exp_q.pop_front());
      n_tests++;
      if ({count, recall, full, busy, beep, err} !== '0) begin
         n_fail++; $display("FAIL live_flags: got cnt=%0d flags=%b want 0", count,
                            {recall, full, busy, beep, err});
      end
      recall_p = 1'b1;
      tick();
      recall_p = 1'b0;
      n_tests++;
      if (err !== 1'b1 || recall !== 1'b0) begin
         n_fail++; $display("FAIL recall_empty: got err=%b recall=%b want 1 0", err, recall);
      end
   endtask

   task automatic test_laps();
      logic [15:0] d, v, e;
      logic        er, b;
      for (int i = 0; i < 3; i++) begin
         v = 16'((i + 1) * 16);
         exp_q.push_back(v);
         do_lap(v, d, er, b);
         e = exp_q.pop_front();
         n_tests++;
         if (d !== e || b !== 1'b1 || er !== 1'b0 || count !== 4'(i + 1)) begin
            n_fail++; $display("FAIL lap%0d: got d=%h b=%b e=%b cnt=%0d want %h 1 0 %0d",
                               i, d, b, er, count, e, i + 1);
         end
      end
      recall_p = 1'b1;
      tick();
      recall_p = 1'b0;
      m_idx = (m_wp + DEPTH - 1) % DEPTH;
      exp_q.push_back(m_mem[m_idx]);
      n_tests++;
      if (recall !== 1'b1 || beep !== 1'b1 || idx !== 3'd2) begin
         n_fail++; $display("FAIL recall_enter: got r=%b beep=%b idx=%0d want 1 1 2", recall, beep, idx);
      end
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (disp_d !== e || disp_d !== 16'h0030) begin
         n_fail++; $display("FAIL recall_newest: got %h want %h", disp_d, e);
      end
   endtask

   task automatic test_next();
      step_next("next1");
      step_next("next2");
      step_next("next3_wrap");
      n_tests++;
      if (disp_d !== 16'h0030) begin
         n_fail++; $display("FAIL next_wrap_const: got %h want 0030", disp_d);
      end
      lap_p = 1'b1;
      tick();
      lap_p = 1'b0;
      n_tests++;
      if (err !== 1'b1 || recall !== 1'b1 || count !== 4'd3) begin
         n_fail++; $display("FAIL lap_in_recall: got err=%b r=%b cnt=%0d want 1 1 3", err, recall, count);
      end
      recall_p = 1'b1;
      next_p   = 1'b1;
      tick();
      recall_p = 1'b0;
      next_p   = 1'b0;
      n_tests++;
      if (recall !== 1'b0 || idx !== 3'd0) begin
         n_fail++; $display("FAIL recall_exit: got r=%b idx=%0d want 0 0", recall, idx);
      end
      next_p = 1'b1;
      tick();
      next_p = 1'b0;
      n_tests++;
      if (recall !== 1'b0 || idx !== 3'd0 || beep !== 1'b0 || err !== 1'b0) begin
         n_fail++; $display("FAIL next_in_live: got r=%b idx=%0d beep=%b err=%b want 0 0 0 0",
                            recall, idx, beep, err);
      end
   endtask

   task automatic test_clear();
      int n_busy = 0, n_beep = 0, n_err = 0, disp_bad = 0;
      live_d  = 16'h5555;
      clear_p = 1'b1;
      lap_p   = 1'b1;
      tick();
      clear_p = 1'b0;
      lap_p   = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (busy) n_busy++;
         if (beep) n_beep++;
         if (err) n_err++;
         if (busy && disp_d !== 16'h0000) disp_bad++;
         lap_p    = (c == 3);
         recall_p = (c == 3);
         tick();
      end
      lap_p    = 1'b0;
      recall_p = 1'b0;
      m_wp = 0; m_cnt = 0; m_idx = 0;
      n_tests++;
      if (n_busy != DEPTH) begin
         n_fail++; $display("FAIL clear_busy_cycles: got %0d want %0d", n_busy, DEPTH);
      end
      n_tests++;
      if (n_beep != 1 || n_err != 0 || disp_bad != 0) begin
         n_fail++; $display("FAIL clear_pulses: got beep=%0d err=%0d disp_bad=%0d want 1 0 0",
                            n_beep, n_err, disp_bad);
      end
      n_tests++;
      if (count !== 4'd0 || full !== 1'b0 || disp_d !== 16'h5555) begin
         n_fail++; $display("FAIL clear_end: got cnt=%0d full=%b disp=%h want 0 0 5555",
                            count, full, disp_d);
      end
   endtask

   task automatic test_full();
      logic [15:0] d, e;
      logic        er, b, was_full;
      for (int i = 1; i <= DEPTH + 1; i++) begin
         was_full = (m_cnt == DEPTH);
         do_lap(16'(i), d, er, b);
         n_tests++;
         if (b !== (!was_full || WRAP) || er !== (was_full && !WRAP)) begin
            n_fail++; $display("FAIL full_lap%0d: got beep=%b err=%b want %b %b", i, b, er,
                               !was_full || WRAP, was_full && !WRAP);
         end
      end
      n_tests++;
      if (count !== 4'd8 || full !== 1'b1) begin
         n_fail++; $display("FAIL full_count: got cnt=%0d full=%b want 8 1", count, full);
      end
      recall_p = 1'b1;
      tick();
      recall_p = 1'b0;
      m_idx = (m_wp + DEPTH - 1) % DEPTH;
      exp_q.push_back(WRAP ? 16'h0009 : 16'h0008);
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (disp_d !== e) begin
         n_fail++; $display("FAIL full_newest: got %h want %h", disp_d, e);
      end
      for (int k = 0; k < DEPTH - 1; k++) step_next("full_step");
      n_tests++;
      if (disp_d !== (WRAP ? 16'h0002 : 16'h0001)) begin
         n_fail++; $display("FAIL full_oldest: got %h want %h", disp_d, WRAP ? 16'h0002 : 16'h0001);
      end
      step_next("full_wrap");
      recall_p = 1'b1;
      tick();
      recall_p = 1'b0;
   endtask

   task automatic test_reset_in_clear();
      int n_beep = 0;
      live_d  = 16'h4321;
      clear_p = 1'b1;
      tick();
      clear_p = 1'b0;
      tick();
      tick();
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL rc_busy: got %b want 1", busy);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({busy, beep, recall, full} !== 4'b0 || count !== 4'd0 || disp_d !== 16'h0000) begin
         n_fail++; $display("FAIL rc_async: got busy=%b beep=%b cnt=%0d disp=%h want 0 0 0 0000",
                            busy, beep, count, disp_d);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         if (beep) n_beep++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (beep) n_beep++;
      end
      n_tests++;
      if (n_beep != 0 || busy !== 1'b0 || disp_d !== 16'h4321) begin
         n_fail++; $display("FAIL rc_no_beep: got beeps=%0d busy=%b disp=%h want 0 0 4321",
                            n_beep, busy, disp_d);
      end
   endtask

   initial begin
      test_reset();
      test_laps();
      test_next();
      test_clear();
      test_full();
      test_reset_in_clear();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
